cntr8_down: RTL and testbench

8-bit loadable down-counter that counts a value it has captured down to zero. It uses the same two-stage ripple of `cla4` carry-look-ahead adders as the up-counter `cntr8`: the decrement is computed as an addition of 8'hFF with carry-in 0. It sits beside `cntr8` in the counter library and serves as a programmable interval timer. A small FSM controls it, and it produces a one-cycle terminal pulse and optional auto-reload.

---
 rtl/cntr8_down.sv | 126 ++++++++++++
 tb/tb_cntr8_down.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cntr8_down.sv
// cntr8_down: 8-bit loadable down-counter / interval timer with terminal pulse
// and optional auto-reload. The decrement is q + 8'hFF through two cla4 stages.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pg
      assign p[gi] = a[gi] ^ b[gi];
      assign g[gi] = a[gi] & b[gi];
      assign s[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Flat look-ahead carries; no carry ripples between bit positions.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign co   = c[4];
endmodule

module cntr8_down (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic       reload,
  output logic [7:0] q,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] q_reg, q_next;
  logic [7:0] rld_reg, rld_next;

  logic [7:0] dec;
  logic       c_mid;
  logic       nonzero;

  // Adding all-ones subtracts one; the final carry is set exactly when q != 0.
  cla4 u_lo (
    .a  (q_reg[3:0]),
    .b  (4'hF),
    .ci (1'b0),
    .s  (dec[3:0]),
    .co (c_mid)
  );

  cla4 u_hi (
    .a  (q_reg[7:4]),
    .b  (4'hF),
    .ci (c_mid),
    .s  (dec[7:4]),
    .co (nonzero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      q_reg     <= 8'h00;
      rld_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      rld_reg   <= rld_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    rld_next   = rld_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          q_next     = load_val;
          rld_next   = load_val;
          state_next = (load_val != 8'h00) ? RUN : DONE;
        end
      end
      RUN: begin
        // The nonzero guard keeps q from ever wrapping below zero.
        if (en && nonzero) begin
          q_next = dec;
          if (q_reg == 8'h01) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (reload && (rld_reg != 8'h00)) begin
          q_next     = rld_reg;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign q    = q_reg;
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
endmodule

// File: tb/tb_cntr8_down.sv
// Scoreboard bench for cntr8_down: a behavioural model queues the expected
// outputs for each driven cycle; they are popped and compared after the edge.

module tb_cntr8_down;
  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] load_val;
  logic       en;
  logic       reload;
  logic [7:0] q;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  int vec_count  = 0;
  int miscompares = 0;

  // Reference model state: 0 idle, 1 run, 2 done
  int         m_state = 0;
  logic [7:0] m_q     = 8'h00;
  logic [7:0] m_rld   = 8'h00;

  int busy_cycles;
  int done_cycles;

  cntr8_down dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .reload   (reload),
    .q        (q),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vec_count++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_state = 0;
      m_q     = 8'h00;
      m_rld   = 8'h00;
    end else begin
      case (m_state)
        0: if (start) begin
          m_q     = load_val;
          m_rld   = load_val;
          m_state = (load_val == 0) ? 2 : 1;
        end
        1: if (en) begin
          m_q = m_q - 8'd1;
          if (m_q == 0) m_state = 2;
        end
        default: begin
          if (reload && m_rld != 0) begin
            m_q     = m_rld;
            m_state = 1;
          end else begin
            m_state = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step(input logic rst_i, input logic start_i, input logic [7:0] ld_i,
                      input logic en_i, input logic rl_i);
    exp_t e;
    reset    = rst_i;
    start    = start_i;
    load_val = ld_i;
    en       = en_i;
    reload   = rl_i;
    model_step();
    e.q    = m_q;
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    $display("rst=%b st=%b ld=%h en=%b rl=%b -> q=%h busy=%b done=%b",
             rst_i, start_i, ld_i, en_i, rl_i, q, busy, done);
    check_val("q", q, e.q);
    check_val("busy", {7'd0, busy}, {7'd0, e.busy});
    check_val("done", {7'd0, done}, {7'd0, e.done});
    if (busy) busy_cycles++;
    if (done) done_cycles++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; load_val = 8'h00; en = 1'b0; reload = 1'b0;

    // Reset with random inputs, then idle
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("idle_q", q, 8'h00);

    // Basic count from 5
    busy_cycles = 0; done_cycles = 0;
    step(1'b0, 1'b1, 8'd5, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("basic_busy_cycles", 8'(busy_cycles), 8'd5);
    check_val("basic_done_cycles", 8'(done_cycles), 8'd1);

    // Full range with en toggling and ignored mid-run start pulses
    done_cycles = 0;
    step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 520; i++)
      step(1'b0, (i % 37) == 5, 8'($urandom), (i % 2) == 0, 1'b0);
    check_val("full_done_cycles", 8'(done_cycles), 8'd1);
    check_val("full_end_q", q, 8'h00);

    // Zero load
    busy_cycles = 0; done_cycles = 0;
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    check_val("zero_done", {7'd0, done}, 8'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("zero_busy_cycles", 8'(busy_cycles), 8'd0);
    check_val("zero_done_cycles", 8'(done_cycles), 8'd1);

    // Auto-reload from 3, then drop reload
    done_cycles = 0;
    step(1'b0, 1'b1, 8'd3, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check_val("reload_done_cycles", 8'(done_cycles), 8'd3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("reload_exit_busy", {7'd0, busy}, 8'd0);

    // Reset mid-count at q=7, then a normal count from 2
    done_cycles = 0;
    step(1'b0, 1'b1, 8'd20, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("pre_reset_q", q, 8'd7);
    step(1'b1, 1'b1, 8'd9, 1'b1, 1'b0);
    check_val("reset_done_cycles", 8'(done_cycles), 8'd0);
    step(1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("post_reset_done_cycles", 8'(done_cycles), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
